// File: rtl/fir_seq_mac.sv
// fir_seq_mac: time-multiplexed FIR core, one shared multiplier, loadable coefficients, valid/ready sample in and saturated result out
module fir_seq_mac #(
  parameter int DATA_W   = 8,
  parameter int COEFF_W  = 8,
  parameter int NUM_TAPS = 4,
  parameter int OUT_W    = 8,
  parameter int SHIFT    = 0,
  localparam int SEL_W   = ($clog2(NUM_TAPS) > 1) ? $clog2(NUM_TAPS) : 1,
  localparam int ACC_W   = DATA_W + COEFF_W + $clog2(NUM_TAPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               coeff_wr,
  input  logic [SEL_W-1:0]   coeff_sel,
  input  logic [COEFF_W-1:0] coeff_data,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_sat,
  output logic               busy
);
  localparam int PW = DATA_W + COEFF_W;
  localparam int RW = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_fin;
  logic [DATA_W-1:0] x_q [NUM_TAPS];
  logic [DATA_W-1:0] x_d [NUM_TAPS];
  logic [COEFF_W-1:0] c_q [NUM_TAPS];
  logic [COEFF_W-1:0] c_d [NUM_TAPS];
  logic out_valid_q, out_valid_d, out_sat_q, out_sat_d, sat;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [PW-1:0] prod;
  logic [RW-1:0] r;
  assign in_ready  = rst_n && ena && state_q == IDLE;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign busy      = state_q != IDLE;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    x_d         = x_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    prod        = PW'(x_q[idx_q]) * PW'(c_q[idx_q]);
    acc_fin     = acc_q + ACC_W'(prod);
    r           = RW'(acc_fin) >> SHIFT;
    sat         = r > RW'({OUT_W{1'b1}});
    if (ena && state_q == IDLE) begin
      if (flush) x_d = '{default: '0};
      for (int k = 0; k < NUM_TAPS; k++)
        if (coeff_wr && coeff_sel == SEL_W'(k)) c_d[k] = coeff_data;
      if (in_valid) begin
        x_d[0] = in_data;
        for (int k = 1; k < NUM_TAPS; k++) x_d[k] = flush ? '0 : x_q[k-1];
        acc_d   = '0;
        idx_d   = '0;
        state_d = MAC;
      end
    end else if (ena && state_q == MAC) begin
      acc_d = acc_fin;
      idx_d = idx_q + SEL_W'(1);
      if (idx_q == SEL_W'(NUM_TAPS - 1)) begin
        out_data_d  = sat ? '1 : r[OUT_W-1:0];
        out_sat_d   = sat;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
    end else if (ena && state_q == OUT && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      x_q         <= '{default: '0};
      c_q         <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end
endmodule
